// File: rtl/lock_verify_pkg.sv
// Shared widths, terminal counter values and FSM state type for the
// key-locked gate verification/unlock sequencer.
package lock_verify_pkg;

    localparam int PAT_W = 4;
    localparam int KEY_W = 3;
    localparam int CNT_W = 5;

    localparam logic [PAT_W-1:0] LAST_PAT = 4'hF;
    localparam logic [KEY_W-1:0] LAST_KEY = 3'h7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/lock_sweep_cnt.sv
// Pattern/key counter pair driving the locked block. Stepping the key
// always restarts the pattern walk at 0.
module lock_sweep_cnt
    import lock_verify_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             step_pat,
    input  logic             step_key,
    input  logic [KEY_W-1:0] key_init,
    output logic [PAT_W-1:0] pat,
    output logic [KEY_W-1:0] key,
    output logic             pat_last,
    output logic             key_last
);

    // clr wins over stepping; a key step overrides a pattern step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat <= '0;
            key <= '0;
        end else if (clr) begin
            pat <= '0;
            key <= key_init;
        end else if (step_key) begin
            pat <= '0;
            key <= key + 1'b1;
        end else if (step_pat) begin
            pat <= pat + 1'b1;
        end
    end

    assign pat_last = (pat == LAST_PAT);
    assign key_last = (key == LAST_KEY);

endmodule

// File: rtl/lock_verify_ctrl.sv
// Verify/search sequencer for the key-locked 4-input block: walks patterns
// (and keys in search mode) and compares the returned Y against GOLDEN.
module lock_verify_ctrl
    import lock_verify_pkg::*;
#(
    parameter logic [15:0] GOLDEN = 16'hB2C4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [KEY_W-1:0] key_in,
    input  logic             abort,
    input  logic             y_in,
    output logic [PAT_W-1:0] pat_out,
    output logic [KEY_W-1:0] key_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [PAT_W-1:0] first_fail,
    output logic [KEY_W-1:0] result_key
);

    state_t state, next_state;

    logic             mode_r;
    logic             mism;
    logic             accept;
    logic             sweep_go;
    logic             sweep_end;
    logic             cnt_clr;
    logic             step_pat;
    logic             step_key;
    logic             pat_last;
    logic             key_last;
    logic [KEY_W-1:0] key_init;

    lock_sweep_cnt u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .step_pat (step_pat),
        .step_key (step_key),
        .key_init (key_init),
        .pat      (pat_out),
        .key      (key_out),
        .pat_last (pat_last),
        .key_last (key_last)
    );

    assign mism     = (y_in != GOLDEN[pat_out]);
    assign accept   = (state == IDLE) && start;
    assign sweep_go = (state == SWEEP) && !abort;

    // Search ends on a clean pass through pat 15 or a failure on the last key
    assign sweep_end = mode_r ? ((mism && key_last) || (!mism && pat_last))
                              : pat_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = SWEEP;
                end
            end
            SWEEP: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (sweep_end) begin
                    next_state = REPORT;
                end
            end
            REPORT: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        done     = (state == REPORT);
        cnt_clr  = accept;
        key_init = mode ? '0 : key_in;
        step_pat = 1'b0;
        step_key = 1'b0;
        if (sweep_go && !sweep_end) begin
            if (mode_r && mism) begin
                step_key = 1'b1;
            end else begin
                step_pat = 1'b1;
            end
        end
    end

    // Abort clears only pass; counts and key results keep their partial values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r         <= 1'b0;
            mismatch_count <= '0;
            first_fail     <= '0;
            pass           <= 1'b0;
            result_key     <= '0;
        end else if (accept) begin
            mode_r         <= mode;
            mismatch_count <= '0;
            first_fail     <= '0;
            pass           <= 1'b0;
        end else if ((state != IDLE) && abort) begin
            pass <= 1'b0;
        end else if (sweep_go) begin
            if (!mode_r && mism) begin
                mismatch_count <= mismatch_count + 1'b1;
                if (mismatch_count == '0) begin
                    first_fail <= pat_out;
                end
            end
            if (sweep_end) begin
                if (mode_r) begin
                    pass       <= !mism;
                    result_key <= mism ? '0 : key_out;
                end else begin
                    pass       <= (mismatch_count == '0) && !mism;
                    result_key <= key_out;
                end
            end
        end
    end

endmodule
